uart_tx_ctrl: RTL and testbench

//  Byte-serialising UART transmitter behind riscv_top's Tx pin. Consumes CPU I/O writes.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encodings, data width,
// and the baud divisor helper.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  // Clocks per bit; integer truncation matches the line-rate tolerance budget.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and first-word fall-through output.
// A push is accepted only when the FIFO is not full before the edge.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  // A same-edge pop never makes room for the push: full is the pre-edge value.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// FIFO-buffered UART transmitter, 8N1 by default; defining UART_PARITY_EN adds an
// even parity bit (8E1). Holds the frame FSM, baud counter and shift register.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [UART_DATA_W-1:0]        wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          ovf,
  output logic                          tx
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;
  logic                   pop;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_dout;
  logic                   bit_end;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign bit_end = (cnt_q == CNT_W'(DIV - 1));
  assign ovf_d   = ovf_q | (wr_en & full);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            // Rotation preserves the XOR, so the shift reg still yields the parity.
            state_d = ST_PAR;
            tx_d    = ^shift_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
            shift_d = {shift_q[0], shift_q[UART_DATA_W-1:1]};
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PAR: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl (CLK_HZ=8, BAUD=1 -> 8 clocks per bit).
// Accepted pushes queue the expected byte; a line monitor decodes tx and compares.
module tb_uart_tx_ctrl;

  localparam int DIV   = 8;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic [3:0] count;
  logic       busy;
  logic       ovf;
  logic       tx;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_frames = 0;
  int start_q[$];
  logic [7:0] exp_q[$];
  logic last_par = 1'b0;

  uart_tx_ctrl #(
    .CLK_HZ     (8),
    .BAUD       (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .count   (count),
    .busy    (busy),
    .ovf     (ovf),
    .tx      (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Called at posedge+#1; the byte is sampled on the next edge.
  task automatic push(input logic [7:0] b, input bit accepted);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted) exp_q.push_back(b);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line monitor: detects start bit, samples mid-bit, compares against the queue.
  initial begin : monitor
    logic       active;
    int         off;
    int         b;
    logic [NB-1:0] fb;
    logic [7:0] e;
    active = 1'b0;
    off = 0;
    fb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          if (tx === 1'b0) begin
            active = 1'b1;
            off = 0;
            start_q.push_back(cyc);
          end
        end else begin
          off++;
        end
        if (active && (off % DIV == DIV / 2)) begin
          b = off / DIV;
          fb[b] = tx;
          if (b == NB - 1) begin
            check("start_bit", 64'(fb[0]), 64'd0);
            check("stop_bit", 64'(fb[NB-1]), 64'd1);
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL unexpected_frame: got %02h expected none", fb[8:1]);
            end else begin
              e = exp_q.pop_front();
              $display("frame data=%02h expected=%02h at start cycle %0d", fb[8:1], e, start_q[$]);
              check("frame_data", 64'(fb[8:1]), 64'(e));
`ifdef UART_PARITY_EN
              check("parity_bit", 64'(fb[9]), 64'(^e));
              last_par = fb[9];
`endif
            end
            n_frames++;
          end
        end
        if (active && off == FRAME - 1) active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    int sidx;
    int nstart;

    // Reset state
    wait_cycles(3);
    check("reset_tx", 64'(tx), 64'd1);
    check("reset_count", 64'(count), 64'd0);
    check("reset_full", 64'(full), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    wait_cycles(2);

    // 1: single frame 0xA5, latency and busy release
    sidx = start_q.size();
    push(8'hA5, 1'b1);
    k = cyc;
    check("t1_count_after_push", 64'(count), 64'd1);
    check("t1_busy_after_push", 64'(busy), 64'd1);
    wait_cycles(1);
    check("t1_tx_start_low", 64'(tx), 64'd0);
    wait_cycles(FRAME - 1);
    check("t1_busy_in_stop", 64'(busy), 64'd1);
    wait_cycles(1);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_nframes", 64'(start_q.size() - sidx), 64'd1);
    if (start_q.size() > sidx) check("t1_start_cycle", 64'(start_q[sidx]), 64'(k + 1));
    wait_cycles(4);

    // 2: back-to-back frames with no idle gap
    sidx = start_q.size();
    push(8'h01, 1'b1);
    push(8'h80, 1'b1);
    wait_cycles(2 * FRAME + 8);
    check("t2_nframes", 64'(start_q.size() - sidx), 64'd2);
    if (start_q.size() >= sidx + 2)
      check("t2_start_gap", 64'(start_q[sidx+1] - start_q[sidx]), 64'(FRAME));
    check("t2_idle", 64'(busy), 64'd0);

    // 3: overflow while busy
    sidx = start_q.size();
    push(8'h11, 1'b1);
    wait_cycles(2);
    for (int i = 0; i < DEPTH; i++) push(8'h20 + 8'(i), 1'b1);
    check("t3_full", 64'(full), 64'd1);
    check("t3_count_full", 64'(count), 64'(DEPTH));
    check("t3_ovf_before_drop", 64'(ovf), 64'd0);
    push(8'h99, 1'b0);
    check("t3_ovf_set", 64'(ovf), 64'd1);
    check("t3_count_after_drop", 64'(count), 64'(DEPTH));
    wait_cycles((DEPTH + 1) * FRAME + 8);
    check("t3_nframes", 64'(start_q.size() - sidx), 64'(DEPTH + 1));
    check("t3_ovf_sticky", 64'(ovf), 64'd1);
    check("t3_idle", 64'(busy), 64'd0);

    // 4: reset in DATA bit3 aborts frame
    push(8'h3C, 1'b1);
    push(8'h55, 1'b1);
    wait_cycles(34);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t4_tx_high", 64'(tx), 64'd1);
    check("t4_count_zero", 64'(count), 64'd0);
    check("t4_ovf_clear", 64'(ovf), 64'd0);
    check("t4_busy_zero", 64'(busy), 64'd0);
    wait_cycles(2);
    rst = 1'b0;
    nstart = start_q.size();
    wait_cycles(2 * FRAME);
    check("t4_no_frames", 64'(start_q.size() - nstart), 64'd0);
    check("t4_tx_idle", 64'(tx), 64'd1);

    // 5: push while full on the same edge as an FSM pop
    sidx = start_q.size();
    push(8'h42, 1'b1);
    k = cyc;
    wait_cycles(3);
    for (int i = 0; i < DEPTH; i++) push(8'hC0 + 8'(i), 1'b1);
    check("t5_full", 64'(full), 64'd1);
    wait_cycles(k + FRAME - cyc);
    push(8'hEE, 1'b0);
    check("t5_ovf", 64'(ovf), 64'd1);
    check("t5_count", 64'(count), 64'(DEPTH - 1));
    check("t5_not_full", 64'(full), 64'd0);
    wait_cycles(DEPTH * FRAME + 8);
    check("t5_nframes", 64'(start_q.size() - sidx), 64'(DEPTH + 1));
    check("t5_idle", 64'(busy), 64'd0);

    // 6: parity values and frame length
    sidx = start_q.size();
    push(8'h07, 1'b1);
    wait_cycles(FRAME + 4);
`ifdef UART_PARITY_EN
    check("t6_parity_07", 64'(last_par), 64'd1);
`endif
    push(8'h03, 1'b1);
    wait_cycles(FRAME + 4);
`ifdef UART_PARITY_EN
    check("t6_parity_03", 64'(last_par), 64'd0);
`endif
    check("t6_nframes", 64'(start_q.size() - sidx), 64'd2);
    if (start_q.size() >= sidx + 2)
      check("t6_frame_len", 64'(start_q[sidx+1] - start_q[sidx]), 64'(FRAME + 5));

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
